// File: rtl/retrans_req_sched.sv
// retrans_req_sched: queues missed MoldUDP64 ranges and issues chunked, retried retransmission requests
// Ports: clk, nreset (sync active-low); miss_* new missed range in; fill_* retransmitted packet seen;
// cfg_timeout_i (0 = wait forever), cfg_retry_i max re-sends; req_* request handshake out;
// full_o FIFO full, drop_o 1-cycle loss pulse, busy_o work pending.
// Optional RETRANS_SCHED_STATS_EN adds saturating stat_req_o/stat_retry_o/stat_drop_o counters.
module retrans_req_sched #(
  parameter int SEQ_NUM_W   = 64,
  parameter int SID_W       = 80,
  parameter int ML_W        = 16,
  parameter int DEPTH       = 4,
  parameter int MAX_REQ_CNT = 64,
  parameter int TO_W        = 16,
  parameter int RETRY_W     = 3
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 miss_v_i,
  input  logic [SID_W-1:0]     miss_sid_i,
  input  logic [SEQ_NUM_W-1:0] miss_start_i,
  input  logic [SEQ_NUM_W-1:0] miss_cnt_i,
  input  logic                 fill_v_i,
  input  logic [SID_W-1:0]     fill_sid_i,
  input  logic [SEQ_NUM_W-1:0] fill_seq_num_i,
  input  logic [ML_W-1:0]      fill_msg_cnt_i,
  input  logic [TO_W-1:0]      cfg_timeout_i,
  input  logic [RETRY_W-1:0]   cfg_retry_i,
  output logic                 req_v_o,
  input  logic                 req_rdy_i,
  output logic [SID_W-1:0]     req_sid_o,
  output logic [SEQ_NUM_W-1:0] req_seq_num_o,
  output logic [ML_W-1:0]      req_cnt_o,
  output logic                 full_o,
  output logic                 drop_o,
  output logic                 busy_o
`ifdef RETRANS_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_req_o,
  output logic [31:0]          stat_retry_o,
  output logic [31:0]          stat_drop_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT} state_t;
  state_t state, nstate;
  logic [SID_W-1:0] mem_sid [DEPTH];
  logic [SEQ_NUM_W-1:0] mem_start [DEPTH];
  logic [SEQ_NUM_W-1:0] mem_cnt [DEPTH];
  logic [AW:0] wp, rp;
  logic [SID_W-1:0] cur_sid;
  logic [SEQ_NUM_W-1:0] cur_seq, rem_cnt, ovl;
  logic [ML_W-1:0] chunk;
  logic [RETRY_W-1:0] retry_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [SEQ_NUM_W:0] fill_end, cur_end;
  logic empty, pop, miss_ok, push, push_drop, fill_hit, done, part, tmo, retry, abandon, acc;
  always_comb begin
    empty = wp == rp;
    full_o = wp == {~rp[AW], rp[AW-1:0]};
    pop = state == S_IDLE && !empty;
    miss_ok = miss_v_i && |miss_cnt_i;
    push = miss_ok && (!full_o || pop);
    push_drop = miss_ok && full_o && !pop;
    fill_end = {1'b0, fill_seq_num_i} + (SEQ_NUM_W+1)'(fill_msg_cnt_i);
    cur_end = {1'b0, cur_seq} + (SEQ_NUM_W+1)'(chunk);
    fill_hit = state == S_WAIT && fill_v_i && fill_sid_i == cur_sid && fill_seq_num_i <= cur_seq;
    done = fill_hit && fill_end >= cur_end;
    // a fill that covers only the head of the chunk shrinks it in place
    part = fill_hit && !done && fill_end > {1'b0, cur_seq};
    ovl = fill_end[SEQ_NUM_W-1:0] - cur_seq;
    // any useful fill in the expiry cycle takes precedence over the timeout
    tmo = state == S_WAIT && !done && !part && to_cnt == TO_W'(1);
    retry = tmo && retry_cnt < cfg_retry_i;
    abandon = tmo && !retry;
    acc = state == S_REQ && req_rdy_i;
  end
  always_ff @(posedge clk)
    if (!nreset) state <= S_IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: nstate = pop ? S_LOAD : S_IDLE;
      S_LOAD: nstate = S_REQ;
      S_REQ: nstate = acc ? S_WAIT : S_REQ;
      S_WAIT: nstate = done ? (rem_cnt == SEQ_NUM_W'(chunk) ? S_IDLE : S_LOAD)
                     : retry ? S_REQ : abandon ? S_IDLE : S_WAIT;
      default: nstate = S_IDLE;
    endcase
  end
  always_comb begin
    req_v_o = state == S_REQ;
    req_sid_o = cur_sid;
    req_seq_num_o = cur_seq;
    req_cnt_o = chunk;
    drop_o = push_drop || abandon;
    busy_o = state != S_IDLE || !empty;
  end
  always_ff @(posedge clk)
    if (push) begin
      mem_sid[wp[AW-1:0]] <= miss_sid_i;
      mem_start[wp[AW-1:0]] <= miss_start_i;
      mem_cnt[wp[AW-1:0]] <= miss_cnt_i;
    end
  always_ff @(posedge clk)
    if (!nreset) begin
      wp <= '0;
      rp <= '0;
      cur_sid <= '0;
      cur_seq <= '0;
      rem_cnt <= '0;
      chunk <= '0;
      retry_cnt <= '0;
      to_cnt <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) begin
        rp <= rp + (AW+1)'(1);
        cur_sid <= mem_sid[rp[AW-1:0]];
        cur_seq <= mem_start[rp[AW-1:0]];
        rem_cnt <= mem_cnt[rp[AW-1:0]];
      end
      if (state == S_LOAD) begin
        chunk <= rem_cnt < SEQ_NUM_W'(MAX_REQ_CNT) ? rem_cnt[ML_W-1:0] : ML_W'(MAX_REQ_CNT);
        retry_cnt <= '0;
      end
      if (acc) to_cnt <= cfg_timeout_i;
      else if (state == S_WAIT && !part && to_cnt != '0) to_cnt <= to_cnt - TO_W'(1);
      if (done) begin
        cur_seq <= cur_seq + SEQ_NUM_W'(chunk);
        rem_cnt <= rem_cnt - SEQ_NUM_W'(chunk);
      end
      if (part) begin
        cur_seq <= cur_seq + ovl;
        rem_cnt <= rem_cnt - ovl;
        chunk <= chunk - ovl[ML_W-1:0];
      end
      if (retry) retry_cnt <= retry_cnt + RETRY_W'(1);
      if (abandon) rem_cnt <= '0;
    end
`ifdef RETRANS_SCHED_STATS_EN
  always_ff @(posedge clk)
    if (!nreset) begin
      stat_req_o <= '0;
      stat_retry_o <= '0;
      stat_drop_o <= '0;
    end else begin
      stat_req_o <= stat_req_o + {31'd0, acc && ~&stat_req_o};
      stat_retry_o <= stat_retry_o + {31'd0, retry && ~&stat_retry_o};
      stat_drop_o <= stat_drop_o + {31'd0, drop_o && ~&stat_drop_o};
    end
`endif
endmodule

// File: tb/tb_retrans_req_sched.sv
// tb_retrans_req_sched: directed vector bench for retrans_req_sched
module tb_retrans_req_sched;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic miss_v_i = 1'b0, fill_v_i = 1'b0, req_rdy_i = 1'b0;
  logic [79:0] miss_sid_i = '0, fill_sid_i = '0;
  logic [63:0] miss_start_i = '0, miss_cnt_i = '0, fill_seq_num_i = '0;
  logic [15:0] fill_msg_cnt_i = '0, cfg_timeout_i = '0;
  logic [2:0] cfg_retry_i = '0;
  logic req_v_o, full_o, drop_o, busy_o;
  logic [79:0] req_sid_o;
  logic [63:0] req_seq_num_o;
  logic [15:0] req_cnt_o;
  int n_vec = 0;
  int n_err = 0;

  retrans_req_sched dut (
    .clk(clk), .nreset(nreset),
    .miss_v_i(miss_v_i), .miss_sid_i(miss_sid_i), .miss_start_i(miss_start_i), .miss_cnt_i(miss_cnt_i),
    .fill_v_i(fill_v_i), .fill_sid_i(fill_sid_i), .fill_seq_num_i(fill_seq_num_i), .fill_msg_cnt_i(fill_msg_cnt_i),
    .cfg_timeout_i(cfg_timeout_i), .cfg_retry_i(cfg_retry_i),
    .req_v_o(req_v_o), .req_rdy_i(req_rdy_i), .req_sid_o(req_sid_o), .req_seq_num_o(req_seq_num_o),
    .req_cnt_o(req_cnt_o), .full_o(full_o), .drop_o(drop_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [79:0] sid;
    logic [63:0] start;
    logic [63:0] cnt;
    logic [63:0] exp_seq;
    logic [15:0] exp_cnt;
    logic [63:0] fill_seq;
    logic [15:0] fill_cnt;
    logic        exp_busy;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (req_v_o !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk("req_wait", req_v_o, 1);
  endtask

  task automatic push(input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
    miss_v_i = 1'b1;
    miss_sid_i = sid;
    miss_start_i = start;
    miss_cnt_i = cnt;
    tick();
    miss_v_i = 1'b0;
  endtask

  task automatic fill(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    fill_v_i = 1'b1;
    fill_sid_i = sid;
    fill_seq_num_i = seq;
    fill_msg_cnt_i = cnt;
    tick();
    fill_v_i = 1'b0;
  endtask

  task automatic accept();
    req_rdy_i = 1'b1;
    tick();
    req_rdy_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc_c[$];
    int ndrop, drop_c;
    logic same, stable;
    logic [159:0] ref_f;
    tbl[0] = '{1'b1, 80'd5, 64'd100, 64'd150, 64'd100, 16'd64, 64'd100, 16'd64, 1'b1};
    tbl[1] = '{1'b0, 80'd5, 64'd0, 64'd0, 64'd164, 16'd64, 64'd164, 16'd64, 1'b1};
    tbl[2] = '{1'b0, 80'd5, 64'd0, 64'd0, 64'd228, 16'd22, 64'd228, 16'd22, 1'b0};
    tbl[3] = '{1'b1, 80'd9, 64'd0, 64'd1, 64'd0, 16'd1, 64'd0, 16'd1, 1'b0};
    tbl[4] = '{1'b1, 80'd3, 64'd1000, 64'd64, 64'd1000, 16'd64, 64'd990, 16'd100, 1'b0};
    tbl[5] = '{1'b1, 80'd2, 64'd500, 64'd65, 64'd500, 16'd64, 64'd500, 16'd64, 1'b1};
    tbl[6] = '{1'b0, 80'd2, 64'd0, 64'd0, 64'd564, 16'd1, 64'd564, 16'd1, 1'b0};
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    chk("rst_req_v", req_v_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_fields", {req_sid_o, req_seq_num_o, req_cnt_o}, 0);
    miss_v_i = 1'b1;
    miss_sid_i = 80'd1;
    miss_cnt_i = 64'd0;
    #1;
    chk("zero_cnt_drop", drop_o, 0);
    tick();
    miss_v_i = 1'b0;
    repeat (3) tick();
    chk("zero_cnt_busy", busy_o, 0);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].push) push(tbl[i].sid, tbl[i].start, tbl[i].cnt);
      wait_req(20);
      chk("vec_sid", req_sid_o, tbl[i].sid);
      chk("vec_seq", req_seq_num_o, tbl[i].exp_seq);
      chk("vec_cnt", req_cnt_o, tbl[i].exp_cnt);
      accept();
      fill(tbl[i].sid, tbl[i].fill_seq, tbl[i].fill_cnt);
      tick();
      chk("vec_busy", busy_o, tbl[i].exp_busy);
    end
    push(80'd4, 64'd200, 64'd10);
    wait_req(20);
    ref_f = {req_sid_o, req_seq_num_o, req_cnt_o};
    chk("bp_fields", ref_f, {80'd4, 64'd200, 16'd10});
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (req_v_o !== 1'b1 || {req_sid_o, req_seq_num_o, req_cnt_o} !== ref_f) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    accept();
    chk("bp_accept_once", req_v_o, 0);
    repeat (5) tick();
    chk("bp_no_resend", req_v_o, 0);
    fill(80'd4, 64'd200, 16'd10);
    tick();
    chk("bp_busy", busy_o, 0);
    cfg_timeout_i = 16'd20;
    cfg_retry_i = 3'd2;
    push(80'd6, 64'd300, 64'd5);
    req_rdy_i = 1'b1;
    ndrop = 0;
    drop_c = -1;
    same = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (req_v_o) begin
        acc_c.push_back(c);
        if ({req_sid_o, req_seq_num_o, req_cnt_o} !== {80'd6, 64'd300, 16'd5}) same = 1'b0;
      end
      if (drop_o) begin
        ndrop++;
        drop_c = c;
      end
    end
    req_rdy_i = 1'b0;
    chk("retry_reqs", acc_c.size(), 3);
    chk("retry_same", same, 1);
    chk("retry_gap", acc_c.size() == 3 && acc_c[1] - acc_c[0] >= 20 && acc_c[2] - acc_c[1] >= 20, 1);
    chk("retry_drops", ndrop, 1);
    chk("retry_drop_late", acc_c.size() == 3 && drop_c - acc_c[2] >= 20, 1);
    chk("retry_idle", busy_o, 0);
    cfg_timeout_i = 16'd0;
    for (int k = 0; k < 6; k++) begin
      miss_v_i = 1'b1;
      miss_sid_i = 80'(11 + k);
      miss_start_i = 64'(10 * k);
      miss_cnt_i = 64'd1;
      #1;
      chk("full_flag", full_o, k == 5);
      chk("full_drop", drop_o, k == 5);
      tick();
    end
    miss_v_i = 1'b0;
    chk("full_hold", full_o, 1);
    for (int i = 0; i < 5; i++) begin
      wait_req(20);
      chk("full_order", {req_sid_o, req_seq_num_o}, {80'(11 + i), 64'(10 * i)});
      accept();
      fill(80'(11 + i), 64'(10 * i), 16'd1);
    end
    repeat (5) tick();
    chk("full_sixth_lost", busy_o, 0);
    cfg_timeout_i = 16'd30;
    cfg_retry_i = 3'd1;
    push(80'd7, 64'd10, 64'd8);
    wait_req(20);
    chk("part_first", {req_sid_o, req_seq_num_o, req_cnt_o}, {80'd7, 64'd10, 16'd8});
    accept();
    repeat (2) tick();
    fill(80'd99, 64'd10, 16'd8);
    fill(80'd7, 64'd10, 16'd3);
    chk("part_no_req", req_v_o, 0);
    wait_req(60);
    chk("part_retry", {req_sid_o, req_seq_num_o, req_cnt_o}, {80'd7, 64'd13, 16'd5});
    accept();
    fill(80'd7, 64'd13, 16'd5);
    tick();
    chk("part_busy", busy_o, 0);
    cfg_timeout_i = 16'd10;
    cfg_retry_i = 3'd3;
    push(80'd8, 64'd50, 64'd70);
    wait_req(20);
    chk("coll_first", {req_sid_o, req_seq_num_o, req_cnt_o}, {80'd8, 64'd50, 16'd64});
    accept();
    repeat (9) tick();
    fill(80'd8, 64'd50, 16'd64);
    wait_req(10);
    chk("coll_next", {req_sid_o, req_seq_num_o, req_cnt_o}, {80'd8, 64'd114, 16'd6});
    accept();
    repeat (3) tick();
    nreset = 1'b0;
    tick();
    chk("rst_mid_req_v", req_v_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    nreset = 1'b1;
    repeat (15) tick();
    chk("rst_mid_drop", drop_o, 0);
    chk("rst_mid_lost", {req_v_o, busy_o}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
